seg_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit common-anode seven-segment display. It owns the anode scan sequence and inserts a dead-time blank between digits to suppress ghosting. It also accepts new display words from an upstream producer (counter, FSM) over a valid/ready handshake. New words are buffered and committed only on frame boundaries, so a frame never shows a torn value.

---
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit seven-segment scan controller with frame-aligned word commit.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic                  disp_en,
  output logic [DIGITS-1:0]     Anode,
  output logic [7:0]            Out,
  output logic                  frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DRIVE_PEN  = CW'(CLK_DIV - 2);
  localparam logic [DW-1:0] TOP_DIG    = DW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DW-1:0]         dig;
  logic [4*DIGITS-1:0]   active_value;
  logic [DIGITS-1:0]     active_dp;
  logic [4*DIGITS-1:0]   pend_value;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pending_full;
  logic                  commit;
  logic                  show;
  logic [3:0]            nib;
  logic [7:0]            drive_pat;
  logic [DIGITS-1:0]     drive_an;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Commit lands on the edge that starts a new frame (or any IDLE edge), never mid-frame.
  assign commit = pending_full &&
                  (state == IDLE ||
                   (state == DRIVE && disp_en && cnt == SLOT_LAST && dig == '0));

  assign nib       = active_value[{dig, 2'b00} +: 4];
  assign drive_pat = {~active_dp[dig], hex_seg(nib)};
  assign drive_an  = ~(DIGITS'(1) << dig);

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    show = (dig == '0) || active_dp[dig];
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(dig) && active_value[4*i +: 4] != 4'h0) show = 1'b1;
    end
  end
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      dig          <= TOP_DIG;
      Anode        <= '1;
      Out          <= 8'hFF;
      frame_done   <= 1'b0;
      active_value <= '0;
      active_dp    <= '0;
      pend_value   <= '0;
      pend_dp      <= '0;
      pending_full <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      if (in_valid && in_ready) begin
        pend_value   <= in_value;
        pend_dp      <= in_dp;
        pending_full <= 1'b1;
        in_ready     <= 1'b0;
      end else if (commit) begin
        active_value <= pend_value;
        active_dp    <= pend_dp;
        pending_full <= 1'b0;
        in_ready     <= 1'b1;
      end

      frame_done <= 1'b0;
      if (!disp_en) begin
        state <= IDLE;
        cnt   <= '0;
        dig   <= TOP_DIG;
        Anode <= '1;
        Out   <= 8'hFF;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            dig   <= TOP_DIG;
          end
          BLANK: begin
            cnt        <= cnt + 1'b1;
            frame_done <= (dig == '0) && (cnt == DRIVE_PEN);
            if (cnt == BLANK_LAST) begin
              state <= DRIVE;
              Anode <= show ? drive_an : '1;
              Out   <= show ? drive_pat : 8'hFF;
            end
          end
          DRIVE: begin
            if (cnt == SLOT_LAST) begin
              state <= BLANK;
              cnt   <= '0;
              dig   <= (dig == '0) ? TOP_DIG : dig - 1'b1;
              Anode <= '1;
              Out   <= 8'hFF;
            end else begin
              cnt        <= cnt + 1'b1;
              frame_done <= (dig == '0) && (cnt == DRIVE_PEN);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - table-driven bench for seg_scan_ctrl (DIGITS=4, CLK_DIV=8, BLANK_CYC=2).
// Honours LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [3:0]  in_dp;
  logic        disp_en;
  logic [3:0]  Anode;
  logic [7:0]  Out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_dp(in_dp), .disp_en(disp_en),
    .Anode(Anode), .Out(Out), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [31:0] outs;   // expected Out per digit, {d3,d2,d1,d0}
    logic [3:0]  blank;  // digits suppressed as leading zeros
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks one 32-cycle frame starting at frame cycle 'first'; optionally offers a word at that cycle.
  task automatic run_frame(input int first, input logic [31:0] outs, input logic [3:0] blank,
                           input logic wr, input logic [15:0] wv, input logic [3:0] wdp);
    logic [3:0] one;
    one = 4'b0001;
    for (int c = first; c < 32; c++) begin
      int d;
      int ph;
      logic dark;
      logic [3:0] ea;
      logic [7:0] eo;
      d = 3 - c / 8;
      ph = c % 8;
      dark = (ph < 2) || blank[d];
      ea = dark ? 4'hF : ~(one << d);
      eo = dark ? 8'hFF : outs[8*d +: 8];
      chk($sformatf("anode c%0d", c), {28'd0, Anode}, {28'd0, ea});
      chk($sformatf("out c%0d", c), {24'd0, Out}, {24'd0, eo});
      chk($sformatf("frame_done c%0d", c), {31'd0, frame_done}, (c == 31) ? 32'd1 : 32'd0);
      if (wr && c == first) begin
        chk("in_ready before write", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_value = wv;
        in_dp    = wdp;
      end
      tick();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] prev;
    logic [3:0]  prev_blank;
    logic [3:0]  zblank;
    int          stall;

`ifdef LEADING_ZERO_BLANK_EN
    zblank = 4'b1110;
    vecs[1] = '{16'h0050, 4'b0000, 32'hC0C092C0, 4'b1100};
`else
    zblank = 4'b0000;
    vecs[1] = '{16'h0050, 4'b0000, 32'hC0C092C0, 4'b0000};
`endif
    vecs[0] = '{16'h12AF, 4'b0010, 32'hF9A4088E, 4'b0000};
    vecs[2] = '{16'h3C8E, 4'b1001, 32'h30C68006, 4'b0000};
    vecs[3] = '{16'h4679, 4'b0000, 32'h9982F890, 4'b0000};
    vecs[4] = '{16'hBD05, 4'b0100, 32'h8321C092, 4'b0000};

    RST = 1'b1; in_valid = 1'b0; in_value = '0; in_dp = '0; disp_en = 1'b0;
    tick(); tick();
    chk("reset anode", {28'd0, Anode}, 32'hF);
    chk("reset out", {24'd0, Out}, 32'hFF);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);

    RST = 1'b0; disp_en = 1'b1;
    tick();
    prev = 32'hC0C0C0C0;
    prev_blank = zblank;
    for (int i = 0; i < 5; i++) begin
      run_frame(0, prev, prev_blank, 1'b1, vecs[i].value, vecs[i].dp);
      prev = vecs[i].outs;
      prev_blank = vecs[i].blank;
    end
    run_frame(0, prev, prev_blank, 1'b0, 16'h0, 4'h0);

    // Back-to-back writes mid-frame: second one stalls until the frame-start commit.
    for (int k = 0; k < 5; k++) tick();
    chk("b2b first ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_value = 16'h1111; in_dp = 4'h0;
    tick();
    in_value = 16'h2222;
    chk("b2b second stalled", {31'd0, in_ready}, 32'd0);
    stall = 0;
    while (!in_ready && stall < 100) begin
      tick();
      stall++;
    end
    chk("b2b stall cycles", stall, 32'd26);
    tick();
    in_valid = 1'b0;
    chk("b2b second accepted", {31'd0, in_ready}, 32'd0);
    run_frame(1, 32'hF9F9F9F9, 4'b0000, 1'b0, 16'h0, 4'h0);
    run_frame(0, 32'hA4A4A4A4, 4'b0000, 1'b0, 16'h0, 4'h0);

    // disp_en dropped during digit 2 drive, then restored.
    for (int k = 0; k < 12; k++) tick();
    chk("digit2 driving", {28'd0, Anode}, 32'hB);
    disp_en = 1'b0;
    tick();
    chk("disabled anode", {28'd0, Anode}, 32'hF);
    chk("disabled out", {24'd0, Out}, 32'hFF);
    tick();
    chk("idle anode", {28'd0, Anode}, 32'hF);
    chk("idle frame_done", {31'd0, frame_done}, 32'd0);
    disp_en = 1'b1;
    tick();
    run_frame(0, 32'hA4A4A4A4, 4'b0000, 1'b0, 16'h0, 4'h0);

    // Reset mid-drive with a word pending.
    for (int k = 0; k < 4; k++) tick();
    in_valid = 1'b1; in_value = 16'h9999; in_dp = 4'hF;
    tick();
    in_valid = 1'b0;
    chk("pending before reset", {31'd0, in_ready}, 32'd0);
    RST = 1'b1;
    tick();
    chk("mid reset anode", {28'd0, Anode}, 32'hF);
    chk("mid reset out", {24'd0, Out}, 32'hFF);
    chk("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    RST = 1'b0;
    tick();
    run_frame(0, 32'hC0C0C0C0, zblank, 1'b0, 16'h0, 4'h0);
    run_frame(0, 32'hC0C0C0C0, zblank, 1'b0, 16'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
